// File: rtl/sound_pkg.sv
// Shared types and the fixed per-event note table for the sound event scheduler.
package sound_pkg;

  typedef enum logic [1:0] {
    EVT_TURN     = 2'd0,
    EVT_GOOD     = 2'd1,
    EVT_BAD      = 2'd2,
    EVT_GAMEOVER = 2'd3
  } evt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  dur;
  } note_t;

  // A divisor of zero terminates an event's pattern.
  function automatic note_t note_lookup(input evt_e evt, input logic [1:0] note);
    note_t n;
    n = '0;
    case (evt)
      EVT_TURN: begin
        if (note == 2'd0) n = '{div: 16'h0200, dur: 8'd1};
      end
      EVT_GOOD: begin
        case (note)
          2'd0:    n = '{div: 16'h0100, dur: 8'd5};
          2'd1:    n = '{div: 16'h00C0, dur: 8'd5};
          default: n = '0;
        endcase
      end
      EVT_BAD: begin
        case (note)
          2'd0:    n = '{div: 16'h0400, dur: 8'd10};
          2'd1:    n = '{div: 16'h0500, dur: 8'd10};
          default: n = '0;
        endcase
      end
      EVT_GAMEOVER: begin
        case (note)
          2'd0:    n = '{div: 16'h0300, dur: 8'd8};
          2'd1:    n = '{div: 16'h0400, dur: 8'd8};
          2'd2:    n = '{div: 16'h0500, dur: 8'd8};
          default: n = '{div: 16'h0600, dur: 8'd16};
        endcase
      end
    endcase
    return n;
  endfunction

  function automatic evt_e highest_evt(input logic [3:0] set);
    if (set[3]) return EVT_GAMEOVER;
    if (set[2]) return EVT_BAD;
    if (set[1]) return EVT_GOOD;
    return EVT_TURN;
  endfunction

endpackage

// File: rtl/sound_note_rom.sv
// Combinational note table lookup: (event, note index) -> divisor and duration.
module sound_note_rom
  import sound_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DUR_W = 8
) (
  input  evt_e             evt,
  input  logic [1:0]       note,
  output logic [DIV_W-1:0] div,
  output logic [DUR_W-1:0] dur
);

  note_t entry;

  always_comb begin
    entry = note_lookup(evt, note);
    div   = DIV_W'(entry.div);
    dur   = DUR_W'(entry.dur);
  end

endmodule

// File: rtl/sound_event_scheduler.sv
// Prioritised game sound sequencer: arbitrates event requests and steps each
// event's note pattern, driving the oscillator with a divisor and an enable.
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DUR_W       = 8,
  parameter int unsigned GAP_TICKS   = 2
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [3:0]       req_i,
  input  logic             mute_i,
  output logic [DIV_W-1:0] tone_div_o,
  output logic             tone_en_o,
  output logic             busy_o,
  output logic [1:0]       active_evt_o,
  output logic             done_o
);

  localparam int unsigned DUR_SPAN  = 1 << DUR_W;
  localparam int unsigned MAX_TICKS = (DUR_SPAN > GAP_TICKS) ? DUR_SPAN : GAP_TICKS;
  localparam int unsigned CNT_W     = $clog2(TICK_CYCLES * MAX_TICKS);
  localparam int unsigned GAP_LEN   = GAP_TICKS * TICK_CYCLES;
  // The LOAD cycle that follows GAP is also silent, so GAP itself is one
  // cycle short and the audible gap between notes is exactly GAP_LEN.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_LEN >= 2) ? GAP_LEN - 2 : 0);

  state_e           state;
  evt_e             active;
  logic [2:0]       note;
  logic [3:0]       pending;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] play_last;

  logic [DIV_W-1:0] rom_div;
  logic [DUR_W-1:0] rom_dur;
  logic [31:0]      dur_ticks;
  logic [CNT_W-1:0] rom_last;
  logic [3:0]       eff;
  logic [3:0]       launch_mask;
  evt_e             top_evt;
  logic             any_req;
  logic             preempt;
  logic             finished;
  logic             launch;

  sound_note_rom #(
    .DIV_W (DIV_W),
    .DUR_W (DUR_W)
  ) u_rom (
    .evt  (active),
    .note (note[1:0]),
    .div  (rom_div),
    .dur  (rom_dur)
  );

  always_comb begin
    eff         = pending | req_i;
    any_req     = |eff;
    top_evt     = highest_evt(eff);
    launch_mask = 4'b0001 << top_evt;
    preempt     = (state != IDLE) && any_req && (top_evt > active);
    finished    = (state == LOAD) && (note[2] || (rom_div == '0));
    launch      = any_req && ((state == IDLE) || preempt || finished);
    dur_ticks   = (rom_dur == '0) ? 32'd1 : 32'(rom_dur);
    rom_last    = CNT_W'(dur_ticks * TICK_CYCLES - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!nRst || mute_i) begin
      state        <= IDLE;
      active       <= EVT_TURN;
      note         <= '0;
      pending      <= '0;
      cnt          <= '0;
      play_last    <= '0;
      tone_div_o   <= '0;
      tone_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      active_evt_o <= '0;
      done_o       <= 1'b0;
    end else begin
      pending <= eff & ~(launch ? launch_mask : 4'b0000);
      done_o  <= finished;
      if (launch) begin
        state        <= LOAD;
        active       <= top_evt;
        note         <= '0;
        cnt          <= '0;
        tone_en_o    <= 1'b0;
        busy_o       <= 1'b1;
        active_evt_o <= top_evt;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (finished) begin
              state        <= IDLE;
              active       <= EVT_TURN;
              busy_o       <= 1'b0;
              active_evt_o <= '0;
              tone_div_o   <= '0;
            end else begin
              state      <= PLAY;
              tone_div_o <= rom_div;
              play_last  <= rom_last;
              cnt        <= '0;
              tone_en_o  <= 1'b1;
            end
          end
          PLAY: begin
            if (cnt >= play_last) begin
              state     <= GAP;
              tone_en_o <= 1'b0;
              cnt       <= '0;
            end else if (cnt != '1) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt >= GAP_LAST) begin
              state <= LOAD;
              note  <= note + 3'd1;
              cnt   <= '0;
            end else if (cnt != '1) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Scoreboard bench for sound_event_scheduler: expected notes and done pulses
// are queued at stimulus time and popped by an independent output monitor.
module tb_sound_event_scheduler;

  localparam int TICK    = 4;
  localparam int GAP_CYC = 2 * TICK;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mute_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [15:0] tone_div_o;
  logic        tone_en_o;
  logic        busy_o;
  logic [1:0]  active_evt_o;
  logic        done_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sound_event_scheduler #(
    .TICK_CYCLES (4),
    .DIV_W       (16),
    .DUR_W       (8),
    .GAP_TICKS   (2)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .req_i        (req_i),
    .mute_i       (mute_i),
    .tone_div_o   (tone_div_o),
    .tone_en_o    (tone_en_o),
    .busy_o       (busy_o),
    .active_evt_o (active_evt_o),
    .done_o       (done_o)
  );

  typedef struct {
    int kind;  // 0 = note, 1 = done pulse
    int cyc;
    int len;
    int div;
    int evt;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int n_notes(input int evt);
    case (evt)
      0:       return 1;
      1:       return 2;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic tbl(input int evt, input int i, output int div, output int dur);
    case (evt * 4 + i)
      0:       begin div = 'h0200; dur = 1;  end
      4:       begin div = 'h0100; dur = 5;  end
      5:       begin div = 'h00C0; dur = 5;  end
      8:       begin div = 'h0400; dur = 10; end
      9:       begin div = 'h0500; dur = 10; end
      12:      begin div = 'h0300; dur = 8;  end
      13:      begin div = 'h0400; dur = 8;  end
      14:      begin div = 'h0500; dur = 8;  end
      default: begin div = 'h0600; dur = 16; end
    endcase
  endtask

  task automatic push_rec(input int kind, input int c, input int len, input int div, input int evt);
    rec_t r;
    r = '{kind: kind, cyc: c, len: len, div: div, evt: evt};
    exp_q.push_back(r);
  endtask

  // l = cycle the event is in LOAD for note 0; d = cycle of its done pulse,
  // which is also the LOAD cycle of any event chained after it.
  task automatic push_seq(input int evt, input int l, output int d);
    int s, div, dur;
    s = l + 1;
    for (int i = 0; i < n_notes(evt); i++) begin
      tbl(evt, i, div, dur);
      push_rec(0, s, dur * TICK, div, evt);
      s = s + dur * TICK + GAP_CYC;
    end
    d = s;
    push_rec(1, d, 0, 0, 0);
  endtask

  task automatic check_obs(input int kind, input int c, input int len, input int div, input int evt);
    rec_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_output: got kind=%0d cyc=%0d len=%0d div=0x%0h evt=%0d, expected nothing",
               kind, c, len, div, evt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != c || e.len != len || e.div != div || e.evt != evt) begin
        miscompares++;
        $display("FAIL output_record: got kind=%0d cyc=%0d len=%0d div=0x%0h evt=%0d, expected kind=%0d cyc=%0d len=%0d div=0x%0h evt=%0d",
                 kind, c, len, div, evt, e.kind, e.cyc, e.len, e.div, e.evt);
      end
    end
  endtask

  bit prev_en = 1'b0;
  int rise_cyc = 0;
  int rise_div = 0;
  int rise_evt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (tone_en_o && !prev_en) begin
        rise_cyc = cyc;
        rise_div = int'(tone_div_o);
        rise_evt = int'(active_evt_o);
      end
      if (!tone_en_o && prev_en) check_obs(0, rise_cyc, cyc - rise_cyc, rise_div, rise_evt);
      if (done_o) check_obs(1, cyc, 0, 0, 0);
      prev_en = tone_en_o;
    end
  end

  task automatic start_req(input logic [3:0] r, output int e);
    @(negedge clk);
    req_i = r;
    e = cyc + 1;
  endtask

  task automatic end_req();
    @(negedge clk);
    req_i = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, int'(busy_o), 0);
    repeat (2) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, g, d, d2, d3, m;

    repeat (3) @(negedge clk);
    chk("reset_outs", int'({tone_div_o, tone_en_o, busy_o, active_evt_o, done_o}), 0);
    nRst = 1'b1;

    // Good: two notes, then done.
    start_req(4'b0010, e);
    push_seq(1, e, d);
    end_req();
    chk("t1_load", int'({busy_o, tone_en_o, active_evt_o}), int'(4'b1001));
    wait_idle("t1");

    // Bad preempted by gameover ten edges later.
    start_req(4'b0100, e);
    end_req();
    repeat (9) @(negedge clk);
    req_i = 4'b1000;
    g = cyc + 1;
    push_rec(0, e + 1, g - e - 1, 'h0400, 2);
    push_seq(3, g, d);
    end_req();
    chk("t2_preempt_load", int'({busy_o, tone_en_o, active_evt_o}), int'(4'b1011));
    @(negedge clk);
    chk("t2_new_div", int'({tone_en_o, tone_div_o}), int'({1'b1, 16'h0300}));
    wait_idle("t2");

    // Gameover with lower-priority requests queued mid-play.
    start_req(4'b1000, e);
    push_seq(3, e, d);
    end_req();
    repeat (5) @(negedge clk);
    start_req(4'b0010, g);
    push_seq(1, d, d2);
    end_req();
    repeat (10) @(negedge clk);
    start_req(4'b0001, g);
    push_seq(0, d2, d3);
    end_req();
    wait_idle("t3");

    // Three simultaneous requests drain in priority order.
    start_req(4'b0111, e);
    push_seq(2, e, d);
    push_seq(1, d, d2);
    push_seq(0, d2, d3);
    end_req();
    wait_idle("t4");

    // Mute mid-play flushes everything; requests under mute are dropped.
    start_req(4'b0010, e);
    end_req();
    repeat (5) @(negedge clk);
    mute_i = 1'b1;
    m = cyc + 1;
    push_rec(0, e + 1, m - e - 1, 'h0100, 1);
    @(negedge clk);
    chk("t5_mute_outs", int'({tone_en_o, busy_o, active_evt_o}), 0);
    req_i = 4'b1000;
    @(negedge clk);
    req_i = '0;
    repeat (3) @(negedge clk);
    mute_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_quiet_after_mute", int'({tone_en_o, busy_o}), 0);

    // Reset in the gap after bad's first note, with good pending.
    start_req(4'b0100, e);
    push_rec(0, e + 1, 10 * TICK, 'h0400, 2);
    end_req();
    repeat (4) @(negedge clk);
    start_req(4'b0010, g);
    end_req();
    while (cyc < e + 42) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    chk("t6_reset_outs", int'({tone_div_o, tone_en_o, busy_o, active_evt_o, done_o}), 0);
    nRst = 1'b1;
    repeat (100) @(negedge clk);
    chk("t6_quiet_after_reset", int'({tone_en_o, busy_o}), 0);

    chk("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_event_scheduler.md
Name: sound_event_scheduler

Overview:
- Arbitrates game sound requests and sequences each event's note pattern: good collision, bad collision, turn and game over.
- Drives the tone datapath with a divisor plus an enable, replacing the direct collision-to-oscillator hookup in the sound top level.
- Each event plays a fixed pattern of up to 4 notes from a note table, separated by silent gaps.
- Higher-priority events preempt lower ones.

Parameters:
- TICK_CYCLES, 100000: clk cycles per duration tick (10 ms at 10 MHz); benches use 4.
- DIV_W, 16: width of the tone divisor.
- DUR_W, 8: width of a note duration, in ticks.
- GAP_TICKS, 2: silent ticks between consecutive notes of one event.

Ports:
- clk  in  1  system clock.
- nRst  in  1  synchronous, active-low reset.
- req_i  in  4  one-cycle event request pulses: [0] turn, [1] good, [2] bad, [3] gameover.
- mute_i  in  1  level; forces silence and flushes all activity.
- tone_div_o  out  DIV_W  divisor for the oscillator; held stable while tone_en_o is high.
- tone_en_o  out  1  oscillator enable.
- busy_o  out  1  high in any state other than IDLE.
- active_evt_o  out  2  index of the event being played; 0 when idle.
- done_o  out  1  one-cycle pulse when a sequence completes naturally (not on preemption).

Behaviour:
- Reset (nRst=0 at a clk edge):
  - State goes to IDLE and all pending bits clear.
  - Tick counter and note index go to 0.
  - All outputs go to 0.
- Pending register (4 bits):
  - A bit sets on its req_i pulse.
  - A bit clears when that event is launched (enters LOAD at note 0).
  - A re-request of the event currently playing sets its pending bit, so it replays after the current sequence; it is never restarted mid-play.
- Priority is fixed: gameover > bad > good > turn. The effective request set is (pending | req_i).
- States and transitions:
  - IDLE: if any effective request, latch the highest-priority one as the active event, note=0, go to LOAD.
  - LOAD: read table[evt][note]. If the divisor is 0 (end marker) or note==4, the sequence is finished: pulse done_o, then go to LOAD for the next pending event if one exists, else IDLE. Otherwise register tone_div_o, clear the tick counter and go to PLAY.
  - PLAY: tone_en_o=1. Hold for exactly dur*TICK_CYCLES cycles, then go to GAP with tone_en_o=0 and the tick counter cleared.
  - GAP: hold for exactly GAP_TICKS*TICK_CYCLES cycles, then note+1 and go to LOAD.
- Preemption: in LOAD, PLAY or GAP, an effective request with priority strictly above the active event causes, on the next edge:
  - the new event is latched with note=0 and the state goes to LOAD;
  - tone_en_o drops;
  - the preempted event is discarded, not resumed, and its pending bit is not re-set.
- Equal or lower-priority requests stay pending and never preempt.
- Latency: a req_i pulse sampled at edge k while IDLE gives LOAD in cycle k+1 and PLAY (tone_en_o=1) from cycle k+2.
- A duration of 0 in the table is treated as 1 tick.
- mute_i=1 has the same effect as reset on state, pending bits and outputs, and req_i is ignored while it is high. When mute_i falls, activity resumes from IDLE with nothing pending.
- Counters saturate safely and never wrap mid-note. The tick counter width is the clog2 of TICK_CYCLES*max(2^DUR_W, GAP_TICKS).
- nRst mid-note: tone_en_o is 0 in the first cycle after the reset edge.

Decomposition:
- sound_pkg holds:
  - the event enum EVT_TURN=0, EVT_GOOD=1, EVT_BAD=2, EVT_GAMEOVER=3;
  - the state enum IDLE/LOAD/PLAY/GAP;
  - the note table constants (divisor, duration in ticks):
    - turn: {0x0200,1};
    - good: {0x0100,5},{0x00C0,5};
    - bad: {0x0400,10},{0x0500,10};
    - gameover: {0x0300,8},{0x0400,8},{0x0500,8},{0x0600,16}.
  - Unused note slots hold divisor 0 (end marker).
- Sub-module sound_note_rom: a combinational lookup of (evt, note[1:0]) to {div, dur} from the package table.
- The scheduler holds the FSM, arbitration, pending register and tick counters.

Test Plan (TICK_CYCLES=4, GAP_TICKS=2):
1. Reset, then pulse req_i=4'b0010 (good) at cycle 0.
   - tone_en_o high cycles 2–21 with tone_div_o=0x0100.
   - Low for 8 cycles, then high for 20 cycles with 0x00C0.
   - After the second gap, done_o pulses once and busy_o falls.
2. Start bad (0100); at cycle 10 pulse gameover (1000).
   - Cycle 11: active_evt_o=3 in LOAD and tone_en_o=0.
   - From cycle 12: tone_div_o=0x0300.
   - Bad never resumes and no done_o is seen for bad.
3. Start gameover; mid-play pulse good then turn.
   - Both stay pending with no preemption.
   - After gameover's done_o: good plays next (0x0100), then turn (0x0200).
4. req_i=4'b0111 in a single cycle.
   - Bad plays first, then good, then turn.
   - Exactly 3 done_o pulses.
5. Assert mute_i mid-PLAY.
   - Next cycle: tone_en_o=0, busy_o=0, active_evt_o=0.
   - Requests during mute have no effect after mute_i falls.
6. Assert nRst=0 during GAP with pending bits set.
   - All outputs are 0 after the edge.
   - No playback occurs afterwards without a new request.
